clock_adjust_fsm: RTL and testbench
===================================

CLOCK_ADJUST_FSM -- requirements
Module: clock_adjust_fsm

Interface
REQ-001 SHALL have parameter HOUR_MAX, default 23, meaning the largest hour value before wrap.
REQ-002 SHALL have parameter MIN_MAX, default 59, meaning the largest minute value before wrap.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low (asserted when 0).
REQ-005 SHALL have port btn_c  input  1  mode pulse, one cycle wide, from the pushbutton detector.
REQ-006 SHALL have port btn_u  input  1  increment pulse, one cycle wide.
REQ-007 SHALL have port btn_d  input  1  decrement pulse, one cycle wide.
REQ-008 SHALL have port btn_l  input  1  select-hour pulse, one cycle wide.
REQ-009 SHALL have port btn_r  input  1  select-minute pulse, one cycle wide.
REQ-010 SHALL have port cur_hour  input  5  live hour from the timekeeper.
REQ-011 SHALL have port cur_min  input  6  live minute from the timekeeper.
REQ-012 SHALL have port mode  output  2  state: 0 CLOCK, 1 SET_TIME, 2 SET_ALARM.
REQ-013 SHALL have port sel  output  1  edited field: 0 minute, 1 hour.
REQ-014 SHALL have port load_time  output  1  one-cycle strobe that commits new_hour/new_min to the timekeeper.
REQ-015 SHALL have port new_hour  output  5  edited hour.
REQ-016 SHALL have port new_min  output  6  edited minute.
REQ-017 SHALL have port alarm_en  output  1  alarm armed.
REQ-018 SHALL have port alarm_ring  output  1  alarm sounding.
REQ-019 SHALL have port disp_hour  output  5  hour to display.
REQ-020 SHALL have port disp_min  output  6  minute to display.

Function
REQ-021 SHALL implement FSM CLOCK->SET_TIME->SET_ALARM->CLOCK, advancing one state per btn_c pulse.
REQ-022 On CLOCK->SET_TIME, new_hour/new_min SHALL load cur_hour/cur_min and sel SHALL be set to 0.
REQ-023 On SET_TIME->SET_ALARM, load_time SHALL be 1 for exactly the next cycle, and sel SHALL be set to 0.
REQ-024 On SET_ALARM->CLOCK, alarm_en SHALL be set to 1.
REQ-025 In SET_TIME and SET_ALARM:
- btn_l SHALL set sel=1; btn_r SHALL set sel=0.
- btn_u/btn_d SHALL increment/decrement the selected field of new_* (SET_TIME) or alarm_* (SET_ALARM).
- Hour wraps HOUR_MAX<->0; minute wraps MIN_MAX<->0; no carry between fields.
REQ-026 In CLOCK, with alarm_ring=0, btn_u SHALL toggle alarm_en; btn_d, btn_l and btn_r SHALL be ignored.
REQ-027 Alarm ringing:
- alarm_ring SHALL be set when mode=CLOCK, alarm_en=1, cur_hour==alarm_hour, cur_min==alarm_min and snooze=0.
- It is visible the cycle after the match.
REQ-028 Silencing:
- While alarm_ring=1, any of btn_u/d/l/r SHALL clear alarm_ring and set internal snooze.
- snooze SHALL clear when cur_* no longer equals alarm_*.
REQ-029 alarm_ring SHALL also clear when the time no longer matches or when mode leaves CLOCK.
REQ-030 Simultaneous pulses:
- btn_c wins over all other buttons.
- Otherwise priority is u > d > l > r; lower-priority pulses in that cycle are dropped.
REQ-031 Display mux (combinational):
- disp_* SHALL be cur_* in CLOCK, new_* in SET_TIME, alarm_* in SET_ALARM.
REQ-032 Latency: every register update SHALL be visible one cycle after the causing pulse.
REQ-033 Values written SHALL never exceed HOUR_MAX/MIN_MAX; out-of-range cur_* values SHALL be copied as-is but wrap to 0 on the next increment.

Reset
REQ-034 When rst=0 at a clock edge, the block SHALL set:
- mode=CLOCK, sel=0, load_time=0;
- new_*=0, alarm_hour=0, alarm_min=0;
- alarm_en=0, alarm_ring=0, snooze=0.
REQ-035 Reset in SET_TIME SHALL discard edits; load_time SHALL NOT be asserted.

Structure
REQ-036 Shared package clock_pkg SHALL hold the mode encoding constants and HOUR_MAX/MIN_MAX defaults.
REQ-037 A sub-module wrap_adjust SHALL be used:
- parameters: MAX, W;
- inputs: val, inc, dec;
- output: next value with wrap.
- One instance is used per field.

Verification
REQ-038 Reset, then 3x btn_c with no edits -> load_time pulses once with 00:00; mode returns to 0; alarm_en=1.
REQ-039 cur=23:59, btn_c, btn_u, btn_l, btn_u -> new=00:00 (min wraps to 00, then hour 23 wraps to 0); disp shows 00:00.
REQ-040 SET_ALARM, sel=0, btn_d from 00 -> alarm_min=59; btn_l then btn_d -> alarm_hour=23.
REQ-041 Alarm 07:30 armed, cur steps to 07:30 -> alarm_ring=1 next cycle; btn_r -> ring=0, stays 0 at 07:30, re-arms after 07:31.
REQ-042 btn_c and btn_u in the same cycle in SET_TIME -> mode=2; new_* unchanged.
REQ-043 rst=0 mid-SET_TIME after edits -> all outputs at reset values; no load_time pulse.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock adjust block: mode encoding, field widths
// and the default wrap limits for hours and minutes.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_e;

  localparam int HOUR_MAX_DEF = 23;
  localparam int MIN_MAX_DEF  = 59;
  localparam int HOUR_W       = 5;
  localparam int MIN_W        = 6;

endpackage

// File: rtl/wrap_adjust.sv
// Single-field increment/decrement with wrap at MAX. Values above MAX wrap to 0
// on increment and clamp to MAX on decrement, so results always stay in range.
module wrap_adjust #(
  parameter int MAX = 59,
  parameter int W   = 6
) (
  input  logic [W-1:0] val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_comb begin
    nxt = val;
    if (inc) begin
      nxt = (val >= MAX_V) ? '0 : val + W'(1);
    end else if (dec) begin
      nxt = ((val == '0) || (val > MAX_V)) ? MAX_V : val - W'(1);
    end
  end

endmodule

// File: rtl/clock_adjust_fsm.sv
// Mode FSM for a digital clock: edits the time and alarm with pushbutton pulses,
// commits edited time to the timekeeper, and drives alarm ringing/snooze.
module clock_adjust_fsm
  import clock_pkg::*;
#(
  parameter int HOUR_MAX = HOUR_MAX_DEF,
  parameter int MIN_MAX  = MIN_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_c,
  input  logic              btn_u,
  input  logic              btn_d,
  input  logic              btn_l,
  input  logic              btn_r,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  output logic [1:0]        mode,
  output logic              sel,
  output logic              load_time,
  output logic [HOUR_W-1:0] new_hour,
  output logic [MIN_W-1:0]  new_min,
  output logic              alarm_en,
  output logic              alarm_ring,
  output logic [HOUR_W-1:0] disp_hour,
  output logic [MIN_W-1:0]  disp_min
);

  mode_e             mode_q, mode_d;
  logic              sel_q, sel_d;
  logic              load_time_q, load_time_d;
  logic [HOUR_W-1:0] new_hour_q, new_hour_d;
  logic [MIN_W-1:0]  new_min_q, new_min_d;
  logic [HOUR_W-1:0] alarm_hour_q, alarm_hour_d;
  logic [MIN_W-1:0]  alarm_min_q, alarm_min_d;
  logic              alarm_en_q, alarm_en_d;
  logic              ring_q, ring_d;
  logic              snooze_q, snooze_d;

  // Resolved button pulses: btn_c beats everything, then u > d > l > r.
  logic u_p, d_p, l_p, r_p, any_p;
  assign u_p   = ~btn_c & btn_u;
  assign d_p   = ~btn_c & ~btn_u & btn_d;
  assign l_p   = ~btn_c & ~btn_u & ~btn_d & btn_l;
  assign r_p   = ~btn_c & ~btn_u & ~btn_d & ~btn_l & btn_r;
  assign any_p = u_p | d_p | l_p | r_p;

  logic time_match;
  assign time_match = (cur_hour == alarm_hour_q) && (cur_min == alarm_min_q);

  // The adjusters operate on whichever register set the current mode is editing.
  logic [HOUR_W-1:0] hour_src, hour_adj;
  logic [MIN_W-1:0]  min_src, min_adj;
  assign hour_src = (mode_q == MODE_SET_ALARM) ? alarm_hour_q : new_hour_q;
  assign min_src  = (mode_q == MODE_SET_ALARM) ? alarm_min_q  : new_min_q;

  wrap_adjust #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour_adj (
    .val (hour_src),
    .inc (u_p & sel_q),
    .dec (d_p & sel_q),
    .nxt (hour_adj)
  );

  wrap_adjust #(.MAX(MIN_MAX), .W(MIN_W)) u_min_adj (
    .val (min_src),
    .inc (u_p & ~sel_q),
    .dec (d_p & ~sel_q),
    .nxt (min_adj)
  );

  always_comb begin
    mode_d       = mode_q;
    sel_d        = sel_q;
    load_time_d  = 1'b0;
    new_hour_d   = new_hour_q;
    new_min_d    = new_min_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    alarm_en_d   = alarm_en_q;
    ring_d       = 1'b0;
    snooze_d     = snooze_q;

    if (!time_match) snooze_d = 1'b0;

    case (mode_q)
      MODE_CLOCK: begin
        if (btn_c) begin
          mode_d     = MODE_SET_TIME;
          new_hour_d = cur_hour;
          new_min_d  = cur_min;
          sel_d      = 1'b0;
        end else if (ring_q && any_p) begin
          snooze_d = 1'b1;
        end else begin
          if (u_p) alarm_en_d = ~alarm_en_q;
          ring_d = alarm_en_q && time_match && !snooze_q;
        end
      end
      MODE_SET_TIME: begin
        if (btn_c) begin
          mode_d      = MODE_SET_ALARM;
          load_time_d = 1'b1;
          sel_d       = 1'b0;
        end else if (l_p) begin
          sel_d = 1'b1;
        end else if (r_p) begin
          sel_d = 1'b0;
        end else if (u_p || d_p) begin
          new_hour_d = hour_adj;
          new_min_d  = min_adj;
        end
      end
      MODE_SET_ALARM: begin
        if (btn_c) begin
          mode_d     = MODE_CLOCK;
          alarm_en_d = 1'b1;
        end else if (l_p) begin
          sel_d = 1'b1;
        end else if (r_p) begin
          sel_d = 1'b0;
        end else if (u_p || d_p) begin
          alarm_hour_d = hour_adj;
          alarm_min_d  = min_adj;
        end
      end
      default: mode_d = MODE_CLOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q       <= MODE_CLOCK;
      sel_q        <= 1'b0;
      load_time_q  <= 1'b0;
      new_hour_q   <= '0;
      new_min_q    <= '0;
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
      alarm_en_q   <= 1'b0;
      ring_q       <= 1'b0;
      snooze_q     <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      sel_q        <= sel_d;
      load_time_q  <= load_time_d;
      new_hour_q   <= new_hour_d;
      new_min_q    <= new_min_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      alarm_en_q   <= alarm_en_d;
      ring_q       <= ring_d;
      snooze_q     <= snooze_d;
    end
  end

  always_comb begin
    disp_hour = cur_hour;
    disp_min  = cur_min;
    if (mode_q == MODE_SET_TIME) begin
      disp_hour = new_hour_q;
      disp_min  = new_min_q;
    end else if (mode_q == MODE_SET_ALARM) begin
      disp_hour = alarm_hour_q;
      disp_min  = alarm_min_q;
    end
  end

  assign mode       = mode_q;
  assign sel        = sel_q;
  assign load_time  = load_time_q;
  assign new_hour   = new_hour_q;
  assign new_min    = new_min_q;
  assign alarm_en   = alarm_en_q;
  assign alarm_ring = ring_q;

endmodule

// File: tb/tb_clock_adjust_fsm.sv
// Directed bench for clock_adjust_fsm: a behavioural model is checked every
// cycle, and literal expectations pin the key scenarios.
module tb_clock_adjust_fsm;

  logic       clk;
  logic       rst;
  logic       btn_c, btn_u, btn_d, btn_l, btn_r;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [1:0] mode;
  logic       sel, load_time, alarm_en, alarm_ring;
  logic [4:0] new_hour, disp_hour;
  logic [5:0] new_min, disp_min;

  clock_adjust_fsm dut (
    .clk(clk), .rst(rst),
    .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
    .cur_hour(cur_hour), .cur_min(cur_min),
    .mode(mode), .sel(sel), .load_time(load_time),
    .new_hour(new_hour), .new_min(new_min),
    .alarm_en(alarm_en), .alarm_ring(alarm_ring),
    .disp_hour(disp_hour), .disp_min(disp_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int HM = 23;
  localparam int MM = 59;

  int n_chk = 0;
  int n_fail = 0;
  int load_cnt = 0;
  bit chk_en = 1'b0;

  // Behavioural model state (mode: 0 clock, 1 set time, 2 set alarm)
  int m_mode = 0, m_sel = 0, m_load = 0;
  int m_nh = 0, m_nm = 0, m_ah = 0, m_am = 0;
  int m_en = 0, m_ring = 0, m_snz = 0;
  int m_btn, p_en, p_snz, p_ring;
  bit m_match;

  function automatic int w_inc(int v, int mx);
    return (v >= mx) ? 0 : v + 1;
  endfunction

  function automatic int w_dec(int v, int mx);
    return (v == 0 || v > mx) ? mx : v - 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs held across it.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_mode = 0; m_sel = 0; m_load = 0; m_nh = 0; m_nm = 0;
      m_ah = 0; m_am = 0; m_en = 0; m_ring = 0; m_snz = 0;
    end else begin
      m_btn = btn_c ? 1 : btn_u ? 2 : btn_d ? 3 : btn_l ? 4 : btn_r ? 5 : 0;
      m_match = (int'(cur_hour) == m_ah) && (int'(cur_min) == m_am);
      p_en = m_en; p_snz = m_snz; p_ring = m_ring;
      m_load = 0;
      m_ring = 0;
      if (!m_match) m_snz = 0;
      if (m_mode == 0) begin
        if (m_btn == 1) begin
          m_mode = 1; m_nh = int'(cur_hour); m_nm = int'(cur_min); m_sel = 0;
        end else if (p_ring != 0 && m_btn != 0) begin
          m_snz = 1;
        end else begin
          if (m_btn == 2) m_en = (p_en != 0) ? 0 : 1;
          m_ring = (p_en != 0 && m_match && p_snz == 0) ? 1 : 0;
        end
      end else if (m_btn == 1) begin
        if (m_mode == 1) begin
          m_mode = 2; m_load = 1; m_sel = 0;
        end else begin
          m_mode = 0; m_en = 1;
        end
      end else if (m_btn == 4) begin
        m_sel = 1;
      end else if (m_btn == 5) begin
        m_sel = 0;
      end else if (m_btn == 2 || m_btn == 3) begin
        if (m_mode == 1 && m_sel != 0) m_nh = (m_btn == 2) ? w_inc(m_nh, HM) : w_dec(m_nh, HM);
        if (m_mode == 1 && m_sel == 0) m_nm = (m_btn == 2) ? w_inc(m_nm, MM) : w_dec(m_nm, MM);
        if (m_mode == 2 && m_sel != 0) m_ah = (m_btn == 2) ? w_inc(m_ah, HM) : w_dec(m_ah, HM);
        if (m_mode == 2 && m_sel == 0) m_am = (m_btn == 2) ? w_inc(m_am, MM) : w_dec(m_am, MM);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (load_time) load_cnt++;
      chk("mode", int'(mode), m_mode);
      chk("sel", int'(sel), m_sel);
      chk("load_time", int'(load_time), m_load);
      chk("new_hour", int'(new_hour), m_nh);
      chk("new_min", int'(new_min), m_nm);
      chk("alarm_en", int'(alarm_en), m_en);
      chk("alarm_ring", int'(alarm_ring), m_ring);
      chk("disp_hour", int'(disp_hour),
          (m_mode == 0) ? int'(cur_hour) : (m_mode == 1) ? m_nh : m_ah);
      chk("disp_min", int'(disp_min),
          (m_mode == 0) ? int'(cur_min) : (m_mode == 1) ? m_nm : m_am);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic c, input logic u, input logic d, input logic l, input logic r);
    btn_c = c; btn_u = u; btn_d = d; btn_l = l; btn_r = r;
    @(negedge clk);
    #1;
    btn_c = 0; btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0;
  endtask

  int lc0;

  initial begin
    rst = 1'b0;
    btn_c = 0; btn_u = 0; btn_d = 0; btn_l = 0; btn_r = 0;
    cur_hour = 5'd0; cur_min = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    #1;
    chk("reset mode", int'(mode), 0);
    chk("reset load_time", int'(load_time), 0);
    chk("reset new", int'(new_hour) * 100 + int'(new_min), 0);
    chk("reset alarm_en/ring/sel", int'({alarm_en, alarm_ring, sel}), 0);
    rst = 1'b1;
    idle(1);

    // Three mode pulses with no edits: one commit of 00:00, alarm armed.
    lc0 = load_cnt;
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    chk("commit strobe", int'(load_time), 1);
    chk("commit value", int'(new_hour) * 100 + int'(new_min), 0);
    pulse(1, 0, 0, 0, 0);
    idle(1);
    chk("commit count", load_cnt - lc0, 1);
    chk("back to clock", int'(mode), 0);
    chk("armed", int'(alarm_en), 1);
    chk("ring at 00:00", int'(alarm_ring), 1);
    pulse(0, 0, 1, 0, 0);
    chk("silenced", int'(alarm_ring), 0);
    cur_hour = 5'd12; cur_min = 6'd0;
    idle(2);

    // Edit from 23:59: minute wraps, then hour wraps.
    cur_hour = 5'd23; cur_min = 6'd59;
    pulse(1, 0, 0, 0, 0);
    chk("copied time", int'(new_hour) * 100 + int'(new_min), 2359);
    pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 0, 1, 0);
    pulse(0, 1, 0, 0, 0);
    chk("wrapped new", int'(new_hour) * 100 + int'(new_min), 0);
    chk("wrapped disp", int'(disp_hour) * 100 + int'(disp_min), 0);

    // Mode pulse beats simultaneous increment.
    pulse(1, 1, 0, 0, 0);
    chk("c beats u mode", int'(mode), 2);
    chk("c beats u new", int'(new_hour) * 100 + int'(new_min), 0);

    // Alarm editing with downward wraps and button priority.
    pulse(0, 0, 1, 0, 0);
    chk("alarm min wrap", int'(disp_min), 59);
    pulse(0, 0, 0, 1, 0);
    pulse(0, 0, 1, 0, 0);
    chk("alarm hour wrap", int'(disp_hour), 23);
    pulse(0, 1, 1, 0, 0);
    chk("u beats d", int'(disp_hour), 0);
    for (int i = 0; i < 7; i++) pulse(0, 1, 0, 0, 0);
    pulse(0, 0, 0, 0, 1);
    pulse(0, 0, 0, 1, 1);
    chk("l beats r", int'(sel), 1);
    pulse(0, 0, 0, 0, 1);
    for (int i = 0; i < 29; i++) pulse(0, 0, 1, 0, 0);
    chk("alarm 07:30", int'(disp_hour) * 100 + int'(disp_min), 730);
    pulse(1, 0, 0, 0, 0);

    // Ring, snooze and re-arm around 07:30.
    cur_hour = 5'd7; cur_min = 6'd29;
    idle(1);
    chk("no ring 07:29", int'(alarm_ring), 0);
    cur_min = 6'd30;
    idle(1);
    chk("ring 07:30", int'(alarm_ring), 1);
    pulse(0, 0, 0, 0, 1);
    chk("snooze r", int'(alarm_ring), 0);
    idle(2);
    chk("stay quiet", int'(alarm_ring), 0);
    cur_min = 6'd31;
    idle(1);
    cur_min = 6'd30;
    idle(1);
    chk("re-armed", int'(alarm_ring), 1);
    pulse(0, 1, 0, 0, 0);
    chk("u silences", int'(alarm_ring), 0);
    chk("u no toggle while ringing", int'(alarm_en), 1);
    cur_hour = 5'd8; cur_min = 6'd0;
    idle(1);
    pulse(0, 1, 0, 0, 0);
    chk("u toggles en", int'(alarm_en), 0);
    pulse(0, 0, 0, 1, 0);
    chk("l ignored in clock", int'(sel), 0);

    // Reset mid-edit discards changes without a commit.
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    chk("edited", int'(new_min), 1);
    lc0 = load_cnt;
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    chk("rst mode", int'(mode), 0);
    chk("rst new", int'(new_hour) * 100 + int'(new_min), 0);
    idle(3);
    chk("rst no commit", load_cnt - lc0, 0);

    // Out-of-range live hour is copied, then wraps to 0 on increment.
    cur_hour = 5'd30; cur_min = 6'd45;
    pulse(1, 0, 0, 0, 0);
    chk("copy out of range", int'(new_hour), 30);
    pulse(0, 0, 0, 1, 0);
    pulse(0, 1, 0, 0, 0);
    chk("oor wraps", int'(new_hour), 0);
    pulse(1, 0, 0, 0, 0);
    pulse(1, 0, 0, 0, 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
